// File: rtl/pipelined_adder.sv
// pipelined_adder: parametrised add/subtract unit split into STAGES
// carry-chained register stages of CW = WIDTH/STAGES bits each, with a
// valid/ready stream interface on both sides and signed-overflow output.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready; a result is taken on a rising edge where
// out_valid && out_ready. The whole pipe advances together when
// adv = !out_valid || out_ready, so in_ready is the only signal with a
// combinational path from an input (out_ready). When adv is low every
// stage, bubbles included, holds its contents and in_valid is ignored.
//
// Stage k adds chunk k of A and B' (B' = sub ? ~B : B) with the carry
// registered by stage k-1. Operand bits not yet consumed ride along in
// shrinking "remainder" registers, and finished result chunks accumulate
// in growing sum registers, so the last stage holds the full-width S.

module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    // Global advance enable shared by every stage.
    logic             adv;
    // Operand B after optional inversion, and the stage-0 carry-in.
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~B : B;
    // Subtraction is A + ~B + 1, so C_in is ignored when sub is set.
    assign cin0     = sub ? 1'b1 : C_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits entering this stage (its own chunk plus the rest).
        localparam int IW = WIDTH - k * CW;
        // Result bits held by this stage once it has added its chunk.
        localparam int SW = (k + 1) * CW;

        logic [IW-1:0] a_src;
        logic [IW-1:0] b_src;
        logic          cin_src;
        logic          vld_src;

        // {carry out, chunk sum} for this stage's slice.
        logic [CW:0]   chunk;
        logic [SW-1:0] sum_d;
        logic          carry_d;
        logic          vld_d;

        logic [SW-1:0] sum_q;
        logic          carry_q;
        logic          vld_q;

        assign chunk = {1'b0, a_src[CW-1:0]}
                     + {1'b0, b_src[CW-1:0]}
                     + {{CW{1'b0}}, cin_src};

        assign carry_d = chunk[CW];
        assign vld_d   = vld_src;

        if (k == 0) begin : g_head
            // First stage is fed straight from the input port.
            assign a_src   = A;
            assign b_src   = b_eff;
            assign cin_src = cin0;
            assign vld_src = in_valid;
            assign sum_d   = chunk[CW-1:0];
        end else begin : g_body
            // Later stages consume the predecessor's remainder and carry,
            // and append their chunk above the already-finished low bits.
            assign a_src   = g_stage[k-1].g_rem.a_rem_q;
            assign b_src   = g_stage[k-1].g_rem.b_rem_q;
            assign cin_src = g_stage[k-1].carry_q;
            assign vld_src = g_stage[k-1].vld_q;
            assign sum_d   = {chunk[CW-1:0], g_stage[k-1].sum_q};
        end

        // Stage result, carry and valid: cleared on reset, loaded on advance.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q   <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (adv) begin
                vld_q   <= vld_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        if (k < STAGES - 1) begin : g_rem
            // Width of the operand bits still to be added by later stages.
            localparam int RW = IW - CW;

            logic [RW-1:0] a_rem_d;
            logic [RW-1:0] b_rem_d;
            logic [RW-1:0] a_rem_q;
            logic [RW-1:0] b_rem_q;

            assign a_rem_d = a_src[IW-1:CW];
            assign b_rem_d = b_src[IW-1:CW];

            // Unconsumed operand bits travel alongside the partial result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (adv) begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_tail
            // Carry into the MSB recovered from the MSB sum bit:
            // sum = a ^ b ^ cin, hence cin = sum ^ a ^ b.
            logic msb_cin;
            logic ovf_d;
            logic ovf_q;

            assign msb_cin = a_src[CW-1] ^ b_src[CW-1] ^ chunk[CW-1];
            assign ovf_d   = msb_cin ^ chunk[CW];

            // Signed overflow registered alongside the final result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign S         = g_stage[STAGES-1].sum_q;
    assign C_out     = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=16, STAGES=4): directed corner cases
// with literal expectations, backpressure, mid-flight reset and a
// randomized stream checked against an arithmetic reference model.

module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int RW     = WIDTH + 2;
    localparam int SMAX   = (1 << (WIDTH - 1)) - 1;
    localparam int SMIN   = -(1 << (WIDTH - 1));
    localparam int UMAX   = (1 << WIDTH) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             C_in      = 1'b0;
    logic             sub       = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] A         = '0;
    logic [WIDTH-1:0] B         = '0;
    logic             in_ready;
    logic             out_valid;
    logic             C_out;
    logic             ovf;
    logic [WIDTH-1:0] S;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C_in      (C_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C_out     (C_out),
        .ovf       (ovf)
    );

    // ---------------- bookkeeping ----------------
    int tests     = 0;
    int fails     = 0;
    int cycle     = 0;
    int out_count = 0;

    // Expected results in acceptance order: {ovf, C_out, S}.
    logic [RW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cycle);
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic logic [RW-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic ci, input logic s);
        int ua, ub, ures, sa, sb, sres;
        logic cout, v;
        logic [WIDTH-1:0] sum;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!s) begin
            ures = ua + ub + int'(ci);
            cout = (ures > UMAX);
            sres = sa + sb + int'(ci);
        end else begin
            ures = ua - ub;
            cout = (ua >= ub);
            sres = sa - sb;
        end
        v   = (sres > SMAX) || (sres < SMIN);
        sum = ures[WIDTH-1:0];
        return {v, cout, sum};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic          stall_prev = 1'b0;
    logic [RW-1:0] prev_out   = '0;
    logic [RW-1:0] got_out;
    logic [RW-1:0] want_out;

    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            got_out = {ovf, C_out, S};
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (stall_prev) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_hold", 32'(got_out), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got 0x%0h, required no result (cycle %0d)", got_out, cycle);
                end else begin
                    want_out = exp_q.pop_front();
                    check("result", 32'(got_out), 32'(want_out));
                end
                out_count++;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_op(A, B, C_in, sub));
            stall_prev = out_valid && !out_ready;
            prev_out   = got_out;
        end
    end

    // ---------------- driver tasks ----------------
    // Present one operation and hold it until accepted.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic s);
        int n;
        A        = a;
        B        = b;
        C_in     = ci;
        sub      = s;
        in_valid = 1'b1;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                timeout_fail("send_accept");
                @(posedge clk);
                #1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Called right after send() returns: result must appear exactly
    // STAGES-1 edges after the accept edge, not earlier.
    task automatic expect_result(input string name, input logic [WIDTH-1:0] s_req,
                                 input logic c_req, input logic v_req);
        repeat (STAGES - 2) @(posedge clk);
        #1;
        check({name, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_S"}, {16'd0, S}, {16'd0, s_req});
        check({name, "_C_out"}, {31'd0, C_out}, {31'd0, c_req});
        check({name, "_ovf"}, {31'd0, ovf}, {31'd0, v_req});
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int base;

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_S", {16'd0, S}, 32'h0000);
        check("reset_C_out", {31'd0, C_out}, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed corner cases with hand-computed results.
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        expect_result("ripple_full", 16'h0000, 1'b1, 1'b0);
        send(16'h00FF, 16'h0000, 1'b1, 1'b0);
        expect_result("ripple_cin", 16'h0100, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        expect_result("signed_ovf", 16'h8000, 1'b0, 1'b1);
        send(16'h0003, 16'h0005, 1'b1, 1'b1);
        expect_result("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        expect_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
        @(posedge clk);
        #1;

        // Backpressure: 8 back-to-back operations, stall 3 cycles after 2nd result.
        base = out_count;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                n = 0;
                while (out_count < base + 2 && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                if (n >= 200) timeout_fail("bp_second_result");
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (out_count < base + 8 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("bp_result_count", 32'(out_count - base), 32'd8);

        // Mid-flight reset: three operations in flight are discarded.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_S", {16'd0, S}, 32'h0000);
        check("flush_C_out", {31'd0, C_out}, 32'd0);
        check("flush_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("flush_quiet", {31'd0, out_valid}, 32'd0);
        end
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        expect_result("post_reset", 16'h5556, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Randomized stream with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = pick_operand();
            B         = pick_operand();
            C_in      = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (STAGES + 2) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
